// File: rtl/alu_exec_unit.sv
// RV32/RV64 execute unit: decodes ALUOp/funct7/funct3 and registers result, zero and illegal flags.
// Latency: 1 cycle for integer and illegal ops; XLEN+1 cycles for M ops when ALU_MULDIV_EN is defined.
// Backpressure: the result is held in DONE until out_ready; in_ready is 0 in BUSY and follows out_ready in DONE.
module alu_exec_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SH_W = CNT_W - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_t;
  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            ill;
  } res_t;

  state_t          state, state_nxt;
  op_t             dec_op;
  res_t            out_q;
  logic            accept, is_m;
  logic [XLEN-1:0] alu_res;
  logic [SH_W-1:0] shamt;

  assign shamt     = op_b[SH_W-1:0];
  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign result    = out_q.res;
  assign zero      = out_q.zero;
  assign illegal   = out_q.ill;

  // Decode the request fields into one operation; anything unrecognised is illegal
  always_comb begin
    dec_op = OP_ILL;
    case (alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      dec_op = OP_SUB;
          else if (funct3 == 3'b101) dec_op = OP_SRA;
        end
`ifdef ALU_MULDIV_EN
        else if (funct7 == 7'b0000001) begin
          case (funct3)
            3'b000:  dec_op = OP_MUL;
            3'b100:  dec_op = OP_DIV;
            3'b101:  dec_op = OP_DIVU;
            3'b110:  dec_op = OP_REM;
            3'b111:  dec_op = OP_REMU;
            default: dec_op = OP_ILL;
          endcase
        end
`endif
      end
      default: dec_op = OP_ILL;
    endcase
  end

`ifdef ALU_MULDIV_EN
  assign is_m = (dec_op == OP_MUL) || (dec_op == OP_DIV) || (dec_op == OP_DIVU) ||
                (dec_op == OP_REM) || (dec_op == OP_REMU);
`else
  assign is_m = 1'b0;
`endif

  // Single-cycle integer datapath; illegal encodings yield 0
  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Iterative M datapath: a_q holds multiplicand / dividend-then-quotient, acc_q product / remainder
  logic [XLEN-1:0]  a_q, b_q, acc_q;
  logic [CNT_W-1:0] cnt;
  op_t              m_op;
  logic             neg_q, neg_r, divz, signed_div, ge;
  logic [XLEN-1:0]  mul_nxt, quo_nxt, rem_nxt, quo_fix, rem_fix, m_res;
  logic [XLEN:0]    rsh;

  assign signed_div = (dec_op == OP_DIV) || (dec_op == OP_REM);

  // One shift-add / restoring-divide step plus the final sign and divide-by-zero fix-up
  always_comb begin
    mul_nxt = acc_q + (b_q[0] ? a_q : '0);
    rsh     = {acc_q, a_q[XLEN-1]};
    ge      = rsh[XLEN] || (rsh[XLEN-1:0] >= b_q);
    rem_nxt = ge ? (rsh[XLEN-1:0] - b_q) : rsh[XLEN-1:0];
    quo_nxt = {a_q[XLEN-2:0], ge};
    quo_fix = divz ? '1 : (neg_q ? -quo_nxt : quo_nxt);
    rem_fix = neg_r ? -rem_nxt : rem_nxt;
    case (m_op)
      OP_MUL:          m_res = mul_nxt;
      OP_DIV, OP_DIVU: m_res = quo_fix;
      default:         m_res = rem_fix;
    endcase
  end

  // Latch magnitudes and sign flags on accept, then advance one step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt   <= '0;
      m_op  <= OP_MUL;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      divz  <= 1'b0;
    end else if (accept && is_m) begin
      m_op  <= dec_op;
      cnt   <= CNT_W'(XLEN);
      acc_q <= '0;
      a_q   <= (signed_div && op_a[XLEN-1]) ? -op_a : op_a;
      b_q   <= (signed_div && op_b[XLEN-1]) ? -op_b : op_b;
      neg_q <= signed_div && (op_a[XLEN-1] ^ op_b[XLEN-1]);
      neg_r <= signed_div && op_a[XLEN-1];
      divz  <= (dec_op != OP_MUL) && (op_b == '0);
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      if (m_op == OP_MUL) begin
        acc_q <= mul_nxt;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
      end else begin
        acc_q <= rem_nxt;
        a_q   <= quo_nxt;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept from IDLE or from DONE in the same cycle the result is taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_m ? BUSY : DONE;
`ifdef ALU_MULDIV_EN
      BUSY: if (cnt == CNT_W'(1)) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = accept ? (is_m ? BUSY : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register result/zero/illegal together when an op completes; held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (accept && !is_m) begin
      out_q.res  <= alu_res;
      out_q.zero <= (alu_res == '0);
      out_q.ill  <= (dec_op == OP_ILL);
    end
`ifdef ALU_MULDIV_EN
    else if ((state == BUSY) && (cnt == CNT_W'(1))) begin
      out_q.res  <= m_res;
      out_q.zero <= (m_res == '0);
      out_q.ill  <= 1'b0;
    end
`endif
  end

endmodule
